// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        DISABLED,
        WARMUP,
        IDLE,
        ISSUE,
        WAIT_BUSY,
        SENDING
    } sched_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin winner select with registered pointer.
// UART_TX_SCHED_PRIO_EN gives requester 0 strict priority over the rotation.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               grant,
    output logic               any_valid,
    output logic [GW-1:0]      winner
);

    logic [GW-1:0]      ptr;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [GW:0]        idx;
    logic               advance;

    always_comb begin
        cand  = valid;
        found = 1'b0;
        idx   = '0;
        winner = '0;
`ifdef UART_TX_SCHED_PRIO_EN
        cand[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ))
                idx = idx - (GW+1)'(NUM_REQ);
            if (!found && cand[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
`ifdef UART_TX_SCHED_PRIO_EN
        if (valid[0])
            winner = '0;
        any_valid = valid[0] | found;
        advance   = grant & ~valid[0] & found;
`else
        any_valid = found;
        advance   = grant & found;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (advance)
            ptr <= (winner == GW'(NUM_REQ-1)) ? '0 : winner + GW'(1);
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources (round-robin).
// Optional macro UART_TX_SCHED_PRIO_EN: requester 0 gets strict priority.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TO_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sched_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_wr,
    output logic                        tx_en,
    input  logic                        tx_busy,
    output logic [grant_w(NUM_REQ)-1:0] grant_id,
    output logic                        err_timeout
);

    localparam int GW = grant_w(NUM_REQ);

    sched_state_t      state, state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic              any_valid;
    logic [GW-1:0]     winner;
    logic              grant;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid    (req_valid),
        .grant    (grant),
        .any_valid(any_valid),
        .winner   (winner)
    );

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (winner == GW'(i))
                sel_data = req_data[DATA_W*i +: DATA_W];
    end

    always_comb begin
        state_nxt   = state;
        tx_en       = 1'b0;
        tx_wr       = 1'b0;
        req_ready   = '0;
        err_timeout = 1'b0;
        grant       = 1'b0;
        case (state)
            DISABLED: if (sched_en) state_nxt = WARMUP;
            WARMUP: begin
                tx_en     = 1'b1;
                state_nxt = IDLE;
            end
            IDLE: begin
                tx_en = 1'b1;
                if (!sched_en)
                    state_nxt = DISABLED;
                // A still-busy transmitter defers arbitration so ISSUE never writes into a live frame.
                else if (any_valid && !tx_busy) begin
                    grant             = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                tx_en     = 1'b1;
                tx_wr     = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tx_en = 1'b1;
                if (tx_busy)
                    state_nxt = SENDING;
                else if (to_cnt == '1) begin
                    err_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SENDING: begin
                tx_en = 1'b1;
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = DISABLED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DISABLED;
            tx_data  <= '0;
            grant_id <= '0;
            to_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                tx_data  <= sel_data;
                grant_id <= winner;
            end
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT_BUSY)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model plus directed scenarios.
module tb_uart_tx_scheduler;

    localparam int N      = 4;
    localparam int TOW    = 6;
    localparam int TO_AGE = 1 << TOW;  // ISSUE cycle is age 0, WAIT_BUSY entered at age 1

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sched_en, tx_busy;
    logic [N-1:0]       req_valid, req_ready;
    logic [8*N-1:0]     req_data;
    logic [7:0]         tx_data;
    logic               tx_wr, tx_en, err_timeout;
    logic [$clog2(N)-1:0] grant_id;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ(N),
        .TO_W   (TOW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_en      (tx_en),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: link on/off, warm-up, and the life of one frame by age.
    bit         m_on, m_warm, m_fr, m_bs;
    int         m_age, m_ptr, m_gid, w;
    logic [7:0] m_data = '0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        int r = -1;
`ifdef UART_TX_SCHED_PRIO_EN
        if (v[0]) return 0;
        v[0] = 1'b0;
`endif
        for (int k = 0; k < N; k++)
            if (r < 0 && v[(p + k) % N]) r = (p + k) % N;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_on = 0; m_warm = 0; m_fr = 0; m_bs = 0;
            m_age = 0; m_ptr = 0; m_gid = 0; m_data = '0;
        end else if (!m_on) begin
            if (sched_en) begin m_on = 1; m_warm = 1; end
        end else if (m_warm) begin
            m_warm = 0;
        end else if (!m_fr) begin
            if (!sched_en) m_on = 0;
            else if (req_valid != '0 && !tx_busy) begin
                w = pick(req_valid, m_ptr);
                m_gid  = w;
                m_data = req_data[8*w +: 8];
`ifdef UART_TX_SCHED_PRIO_EN
                if (w != 0) m_ptr = (w + 1) % N;
`else
                m_ptr = (w + 1) % N;
`endif
                m_fr = 1; m_age = 0; m_bs = 0;
            end
        end else begin
            if (m_age >= 1 && !m_bs) begin
                if (tx_busy) m_bs = 1;
                else if (m_age == TO_AGE) m_fr = 0;
            end else if (m_bs && !tx_busy) m_fr = 0;
            m_age++;
        end
    end

    // Observation and per-cycle compare.
    logic       wr_s = 1'b0;
    logic [N-1:0] hs_s = '0;
    int         cyc_no = 0, wr_cyc = 0, err_cyc = 0, err_cnt = 0;
    int         rdy_cnt [N];
    int         log_gid [$];
    int         log_dat [$];

    always @(negedge clk) begin
        logic [N-1:0] er;
        er = '0;
        if (m_on && !m_warm && !m_fr && sched_en && req_valid != '0 && !tx_busy)
            er[pick(req_valid, m_ptr)] = 1'b1;
        chk("tx_en", tx_en, m_on);
        chk("tx_wr", tx_wr, m_fr && m_age == 0);
        chk("req_ready", req_ready, er);
        chk("err_timeout", err_timeout, m_fr && !m_bs && m_age == TO_AGE && !tx_busy);
        chk("tx_data", tx_data, m_data);
        chk("grant_id", grant_id, m_gid);
        wr_s = tx_wr;
        hs_s = req_ready & req_valid;
        if (tx_wr) begin
            log_gid.push_back(int'(grant_id));
            log_dat.push_back(int'(tx_data));
            wr_cyc = cyc_no;
        end
        if (err_timeout) begin err_cnt++; err_cyc = cyc_no; end
        for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
        cyc_no++;
    end

    // Stimulus: requesters and a transmitter that stays busy busy_len cycles after each write.
    int busy_len = 20, bl = 0;
    bit refill = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (reset) bl = 0;
        else if (wr_s && busy_len > 0) bl = busy_len;
        else if (bl > 0) bl--;
        tx_busy = (bl > 0);
        for (int i = 0; i < N; i++)
            if (hs_s[i] && !reset) begin
                if (refill) req_data[8*i +: 8] = req_data[8*i +: 8] + 8'd1;
                else req_valid[i] = 1'b0;
            end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (log_gid.size() < n && k < budget) begin cyc(); k++; end
        chk(nm, log_gid.size() >= n, 1);
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!tx_busy && k < budget) begin cyc(); k++; end
        chk("busy_rise_wait", tx_busy, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
        sched_en = 0; req_valid = '0; req_data = '0; tx_busy = 0;

        // Reset state
        run(3);
        @(negedge clk);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        cyc();
        reset = 0;

        // Enable and first request from requester 2
        sched_en = 1;
        cyc();
        @(negedge clk);
        chk("warmup_tx_en", tx_en, 1);
        chk("warmup_no_wr", tx_wr, 0);
        cyc();
        req_valid[2] = 1'b1; req_data[23:16] = 8'hA5;
        wait_log(1, 10, "first_grant_wait");
        chk("first_gid", log_gid[0], 2);
        chk("first_data", log_dat[0], 8'hA5);
        run(30);
        chk("first_ready_pulses", rdy_cnt[2], 1);

        // Round-robin across four continuously valid requesters
        reset = 1; run(2); reset = 0;
        refill = 1; req_data = 32'h40302010; req_valid = 4'b1111;
        n = log_gid.size();
        wait_log(n + 5, 200, "rr_wait");
        req_valid = '0; refill = 0;
        chk("rr_gid0", log_gid[n],   0);
        chk("rr_gid1", log_gid[n+1], 1);
        chk("rr_gid2", log_gid[n+2], 2);
        chk("rr_gid3", log_gid[n+3], 3);
        chk("rr_gid4", log_gid[n+4], 0);
        chk("rr_dat0", log_dat[n],   8'h10);
        chk("rr_dat3", log_dat[n+3], 8'h40);
        chk("rr_dat4", log_dat[n+4], 8'h11);
        run(30);

        // Timeout: transmitter never raises busy
        busy_len = 0;
        req_data[15:8] = 8'h5A; req_valid[1] = 1'b1;
        n = 0;
        while (err_cnt == 0 && n < 150) begin cyc(); n++; end
        chk("to_fired", err_cnt, 1);
        chk("to_latency_from_wr", err_cyc - wr_cyc, 64);
        run(3);
        chk("to_single_pulse", err_cnt, 1);
        busy_len = 20;
        req_data[31:24] = 8'h77; req_valid[3] = 1'b1;
        n = log_gid.size();
        wait_log(n + 1, 10, "post_to_wait");
        chk("post_to_gid", log_gid[n], 3);
        chk("post_to_data", log_dat[n], 8'h77);
        run(30);

        // Disable while a frame is in flight
        req_data[7:0] = 8'h99; req_valid[0] = 1'b1;
        wait_busy(10);
        sched_en = 0; req_valid = 4'b1111;
        n = log_gid.size();
        run(40);
        chk("dis_no_grant", log_gid.size(), n);
        @(negedge clk);
        chk("dis_tx_en", tx_en, 0);
        cyc();
        req_valid = '0;

        // Asynchronous reset in the middle of a frame
        sched_en = 1;
        run(3);
        req_data[23:16] = 8'hC3; req_valid[2] = 1'b1;
        wait_busy(10);
        run(5);
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_tx_en", tx_en, 0);
        chk("arst_tx_wr", tx_wr, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_gid", grant_id, 0);
        chk("arst_err", err_timeout, 0);
        req_data[15:8] = 8'h3C; req_valid = 4'b0010;
        cyc(); cyc();
        reset = 0;
        n = log_gid.size();
        wait_log(n + 1, 20, "arst_recover_wait");
        chk("arst_rec_gid", log_gid[n], 1);
        chk("arst_rec_data", log_dat[n], 8'h3C);
        run(30);

`ifdef UART_TX_SCHED_PRIO_EN
        // Strict priority for requester 0
        refill = 1; req_valid = 4'b0011;
        n = log_gid.size();
        wait_log(n + 4, 200, "prio_wait");
        req_valid[0] = 1'b0;
        wait_log(n + 5, 60, "prio_r1_wait");
        req_valid = '0; refill = 0;
        for (int i = 0; i < 4; i++) chk("prio_gid0", log_gid[n+i], 0);
        chk("prio_gid1", log_gid[n+4], 1);
        run(30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
